carregador_instrucoes_uart: RTL
===============================

# carregador_instrucoes_uart

UART boot loader that writes program words into the processor's instruction memory. It receives an 8N1 serial stream, checks a length header, assembles big-endian 32-bit words and issues one write strobe per word at consecutive word addresses. It holds the pipeline in reset (`segurar_cpu`) until the image is complete. It is the writer side of the instruction memory that the fetch stage reads.

## Interface
- `CLKS_POR_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- `LARG_END`, 7, instruction-memory word-address width; capacity is 2**LARG_END words.
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input; idles high; asynchronous to `clock`.
- `mem_escrever` out 1: one-cycle write strobe to instruction memory.
- `mem_endereco` out LARG_END: word address for the write.
- `mem_dado` out 32: word to write.
- `segurar_cpu` out 1: high while loading; low only in CONCLUIDO.
- `pronto` out 1: image loaded successfully; sticky.
- `erro` out 1: framing, length or checksum error; sticky.

## Operation
- `rx` passes through a 2-flop synchronizer. Receiver FSM states:
  - OCIOSO: leaves on a synchronized low.
  - START: samples after CLKS_POR_BIT/2 cycles; if high, returns to OCIOSO as a glitch with no error.
  - DADOS: 8 samples spaced CLKS_POR_BIT apart, LSB first.
  - PARADA: samples the stop bit. If the stop bit is high, the receiver pulses `byte_ok` internally for one cycle. If it is low, this is a framing error and the loader enters ERRO.
- Loader FSM states:
  - TAM_H, TAM_L: the first two bytes form the 16-bit word count N, MSB first.
  - Length check after TAM_L: N > 2**LARG_END goes to ERRO. N = 0 goes to CHECKSUM or CONCLUIDO. Otherwise go to PALAVRA.
  - PALAVRA: shifts bytes into a 32-bit register MSB-first, with a 2-bit byte counter. On the 4th byte it drives `mem_dado` and `mem_endereco` = word index, pulses `mem_escrever`, then increments the index. After the Nth word it goes to CHECKSUM or CONCLUIDO.
  - CONCLUIDO: `pronto`=1, `segurar_cpu`=0. Further `rx` traffic is ignored.
  - ERRO: `erro`=1, `segurar_cpu`=1. Only `reset_n` exits this state.
- Word index counter is LARG_END+1 bits wide, so it cannot overflow for N ≤ 2**LARG_END.
- Reset values: `mem_escrever`=0, `mem_endereco`=0, `mem_dado`=0, `segurar_cpu`=1, `pronto`=0, `erro`=0. Both FSMs go to OCIOSO/TAM_H, and all counters are cleared.
- Reset asserted mid-frame or mid-word discards the partial byte or word. Memory contents already written are not cleared.

## Timing
- Start-bit check at cycle CLKS_POR_BIT/2 after the synchronized falling edge. Data bit k is sampled at CLKS_POR_BIT/2 + (k+1)·CLKS_POR_BIT; the stop bit at +9·CLKS_POR_BIT.
- `byte_ok` occurs the cycle after the stop sample. `mem_escrever` asserts the cycle after the 4th `byte_ok`, lasts exactly 1 cycle, and `mem_dado`/`mem_endereco` are stable during it. Both hold their value until the next write.
- Transitions:
  - `segurar_cpu` falls and `pronto` rises together, in the cycle after the final write strobe, or after checksum acceptance when the checksum is enabled.
  - `erro` rises the cycle after the failing stop sample or after the length/checksum decision.
- Back-to-back frames need no idle time: the receiver re-arms in OCIOSO in the cycle after PARADA.
- Input latency is 2 cycles of synchronizer delay on `rx`.

## Configuration
- `CARREGADOR_CHECKSUM_EN` defined: after the last word (or directly after the header when N=0), the loader expects one byte equal to the XOR of every previously received byte, header bytes included. A match goes to CONCLUIDO; a mismatch goes to ERRO. Memory writes have already occurred and are not undone.
- Not defined: the CHECKSUM state and the XOR accumulator are absent, and the loader goes directly to CONCLUIDO.

## Test plan
All scenarios use CLKS_POR_BIT=16 and LARG_END=7.
- Header 00 02, bytes 20 08 00 05 8C 09 00 04 → writes (0, 0x20080005) and (1, 0x8C090004), one strobe each; then `pronto`=1 and `segurar_cpu`=0.
- 1-cycle-wide-by-6-cycle low glitch on `rx` while idle → no `byte_ok`, no error, state unchanged.
- Header 00 01, then a byte with stop bit = 0 → `erro`=1, no `mem_escrever`, `segurar_cpu` stays 1.
- Header 00 81 (N=129 > 128) → `erro`=1 right after the header, with zero writes. Header 00 00 → `pronto` with no writes (checksum disabled).
- Assert `reset_n` low after 2 bytes of word 0, then resend the full image of scenario 1 → writes start again at address 0 with correct data, and outputs return to reset values during reset.
- With `CARREGADOR_CHECKSUM_EN` defined: image 00 01 11 22 33 44 followed by checksum 0x45 → `pronto`. The same image followed by 0x00 → `erro`, with the word write already issued.

Source files
------------

// File: rtl/carregador_instrucoes_uart.sv
// UART 8N1 boot loader: length header, big-endian 32-bit words written to instruction memory.
// Optional trailing XOR checksum byte when CARREGADOR_CHECKSUM_EN is defined.
module carregador_instrucoes_uart #(
  parameter int CLKS_POR_BIT = 434,
  parameter int LARG_END     = 7
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx,
  output logic                mem_escrever,
  output logic [LARG_END-1:0] mem_endereco,
  output logic [31:0]         mem_dado,
  output logic                segurar_cpu,
  output logic                pronto,
  output logic                erro
);

  localparam int CW = $clog2(CLKS_POR_BIT);
  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_POR_BIT - 1);
  localparam logic [CW-1:0] FIM_MEIO = CW'(CLKS_POR_BIT / 2 - 1);
  localparam logic [16:0]   CAPACIDADE = 17'(2 ** LARG_END);

  typedef enum logic [1:0] {OCIOSO, START, DADOS, PARADA} rx_estado_t;
  typedef enum logic [2:0] {TAM_H, TAM_L, PALAVRA, CHECKSUM, CONCLUIDO, ERRO} car_estado_t;

`ifdef CARREGADOR_CHECKSUM_EN
  localparam car_estado_t FIM = CHECKSUM;
`else
  localparam car_estado_t FIM = CONCLUIDO;
`endif

  logic rx_meta_q, rx_sinc_q;

  rx_estado_t    rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          byte_ok_q, byte_ok_d;
  logic          erro_quadro;

  car_estado_t         car_q, car_d;
  logic [15:0]         n_q, n_d, n_novo;
  logic [23:0]         palavra_q, palavra_d;
  logic [1:0]          nbyte_q, nbyte_d;
  logic [LARG_END:0]   indice_q, indice_d;
  logic                mem_escrever_q, mem_escrever_d;
  logic [LARG_END-1:0] mem_endereco_q, mem_endereco_d;
  logic [31:0]         mem_dado_q, mem_dado_d;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sinc_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sinc_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_q      <= OCIOSO;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      byte_ok_q <= 1'b0;
    end else begin
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      byte_ok_q <= byte_ok_d;
    end
  end

  // The framing error is decoded combinationally so the loader reaches ERRO on the stop-sample edge.
  always_comb begin
    rx_d        = rx_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    sr_d        = sr_q;
    byte_ok_d   = 1'b0;
    erro_quadro = 1'b0;
    unique case (rx_q)
      OCIOSO: begin
        cnt_d = '0;
        if (!rx_sinc_q) rx_d = START;
      end
      START: begin
        if (cnt_q == FIM_MEIO) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rx_sinc_q ? OCIOSO : DADOS;
        end
      end
      DADOS: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d = '0;
          sr_d  = {rx_sinc_q, sr_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_d = PARADA;
        end
      end
      PARADA: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d       = '0;
          rx_d        = OCIOSO;
          byte_ok_d   = rx_sinc_q;
          erro_quadro = !rx_sinc_q;
        end
      end
      default: rx_d = OCIOSO;
    endcase
  end

  assign n_novo = {n_q[15:8], sr_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      car_q          <= TAM_H;
      n_q            <= '0;
      palavra_q      <= '0;
      nbyte_q        <= '0;
      indice_q       <= '0;
      mem_escrever_q <= 1'b0;
      mem_endereco_q <= '0;
      mem_dado_q     <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      car_q          <= car_d;
      n_q            <= n_d;
      palavra_q      <= palavra_d;
      nbyte_q        <= nbyte_d;
      indice_q       <= indice_d;
      mem_escrever_q <= mem_escrever_d;
      mem_endereco_q <= mem_endereco_d;
      mem_dado_q     <= mem_dado_d;
`ifdef CARREGADOR_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  always_comb begin
    car_d          = car_q;
    n_d            = n_q;
    palavra_d      = palavra_q;
    nbyte_d        = nbyte_q;
    indice_d       = indice_q;
    mem_escrever_d = 1'b0;
    mem_endereco_d = mem_endereco_q;
    mem_dado_d     = mem_dado_q;
`ifdef CARREGADOR_CHECKSUM_EN
    xor_d          = xor_q;
    if (byte_ok_q && (car_q == TAM_H || car_q == TAM_L || car_q == PALAVRA))
      xor_d = xor_q ^ sr_q;
`endif
    unique case (car_q)
      TAM_H: begin
        if (erro_quadro) car_d = ERRO;
        else if (byte_ok_q) begin
          n_d   = {sr_q, n_q[7:0]};
          car_d = TAM_L;
        end
      end
      TAM_L: begin
        if (erro_quadro) car_d = ERRO;
        else if (byte_ok_q) begin
          n_d = n_novo;
          if ({1'b0, n_novo} > CAPACIDADE) car_d = ERRO;
          else if (n_novo == 16'd0)       car_d = FIM;
          else                            car_d = PALAVRA;
        end
      end
      PALAVRA: begin
        // Leave only after the final strobe so pronto rises the cycle after it.
        if (erro_quadro) car_d = ERRO;
        else if (mem_escrever_q && 16'(indice_q) == n_q) car_d = FIM;
        else if (byte_ok_q) begin
          palavra_d = {palavra_q[15:0], sr_q};
          nbyte_d   = nbyte_q + 1'b1;
          if (nbyte_q == 2'd3) begin
            mem_escrever_d = 1'b1;
            mem_dado_d     = {palavra_q, sr_q};
            mem_endereco_d = indice_q[LARG_END-1:0];
            indice_d       = indice_q + 1'b1;
          end
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      CHECKSUM: begin
        if (erro_quadro) car_d = ERRO;
        else if (byte_ok_q) car_d = (sr_q == xor_q) ? CONCLUIDO : ERRO;
      end
`endif
      default: car_d = car_q;
    endcase
  end

  assign mem_escrever = mem_escrever_q;
  assign mem_endereco = mem_endereco_q;
  assign mem_dado     = mem_dado_q;
  assign segurar_cpu  = (car_q != CONCLUIDO);
  assign pronto       = (car_q == CONCLUIDO);
  assign erro         = (car_q == ERRO);

endmodule
